ex_mem_wb_pipe: RTL and testbench
=================================

Name: ex_mem_wb_pipe

Overview:
Back end of the 5-stage pipeline, downstream of the execute stage. Holds the EX/MEM and MEM/WB pipeline registers and resolves taken branches in MEM. Produces everything the execute stage consumes from later stages: forwarding selects (forwardA/forwardB), ALU_OUT_MEM and ALU_DATA_WB. Also self-flushes the wrong-path instruction behind a taken branch and keeps a retired-instruction counter.

Parameters:
CNT_W, 32, width of the INSTRET retire counter
RA_W, 5, register address width

Ports:
clk  input  1  pipeline clock, all state on rising edge
reset  input  1  synchronous, active-high; clears all state
VALID_EX  input  1  EX holds a real instruction (0 = bubble)
RegWrite_EX  input  1  EX-stage writeback enable
MemtoReg_EX  input  1  EX-stage writeback source is memory
MemRead_EX  input  1  EX-stage load
MemWrite_EX  input  1  EX-stage store
Branch_EX  input  1  EX-stage branch
ZERO_EX  input  1  ALU zero flag
ALU_OUT_EX  input  32  ALU result
REG_DATA2_EX_FINAL  input  32  store data from EX
PC_Branch_EX  input  32  branch target
RD_EX  input  RA_W  destination register in EX
RS1_EX  input  RA_W  source 1 of the instruction in EX
RS2_EX  input  RA_W  source 2 of the instruction in EX
FLUSH_MEM  input  1  external bubble request into EX/MEM
DATA_MEM_RD  input  32  data-memory read data for the current MEM address (combinational memory)
ALU_OUT_MEM  output  32  registered ALU result; also the data-memory address
STORE_DATA_MEM  output  32  registered store data
MemRead_MEM  output  1  registered MemRead
MemWrite_MEM  output  1  registered MemWrite
PC_Branch_MEM  output  32  registered branch target
PCSrc_MEM  output  1  taken-branch redirect to fetch
RD_WB  output  RA_W  writeback destination
RegWrite_WB  output  1  writeback enable
ALU_DATA_WB  output  32  writeback data
forwardA  output  2  operand-A select for EX
forwardB  output  2  operand-B select for EX
INSTRET  output  CNT_W  retired-instruction count

Behaviour:
- Reset (sync, high): every register cleared, including VALID, control bits, data, RD fields and INSTRET. Resulting outputs are all 0: PCSrc_MEM=0, forwardA=forwardB=00, ALU_DATA_WB=0. Reset has priority over every other event; an in-flight instruction is dropped.
- EX/MEM register, updated every edge, with no stall:
  - If PCSrc_MEM=1 or FLUSH_MEM=1, it loads a bubble: VALID and all control 0, RD 0, data 0.
  - Otherwise it captures the EX inputs. When VALID_EX=0, control bits are forced to 0.
- MEM/WB register, updated every edge: captures VALID_MEM, RegWrite_MEM, MemtoReg_MEM, RD_MEM, ALU_OUT_MEM and DATA_MEM_RD.
- PCSrc_MEM = VALID_MEM & Branch_MEM & ZERO_MEM (combinational from EX/MEM). The redirect is visible for exactly one cycle per taken branch. The bubble it forces also clears Branch_MEM on the next edge, so back-to-back redirects cannot occur.
- ALU_DATA_WB = MemtoReg_WB ? MEM_DATA_WB : ALU_OUT_WB (combinational).
- Forwarding is combinational from RS1_EX/RS2_EX; shown for A, B is identical with RS2_EX:
  - 10 if RegWrite_MEM & RD_MEM!=0 & RD_MEM==RS1_EX;
  - else 01 if RegWrite_WB & RD_WB!=0 & RD_WB==RS1_EX;
  - else 00.
  - MEM has priority over WB. x0 never forwards.
  - Encoding: 00 = register file, 01 = ALU_DATA_WB, 10 = ALU_OUT_MEM.
- Load-use: the ID-stage stall guarantees that a load in MEM never matches RS1_EX/RS2_EX. This block does not detect that case.
- INSTRET increments by 1 on each edge where VALID_WB=1 and reset=0. It wraps from 2^CNT_W-1 to 0. Bubbles and flushed instructions are never counted.
- Latency: an EX input appears at the MEM outputs 1 cycle later and at the WB outputs 2 cycles later.

Test Plan:
1. Reset mid-stream: reset=1 on an edge with a valid RegWrite instruction in MEM and in WB. Next cycle: all outputs 0, INSTRET=0, forwardA/forwardB=00; the dropped instructions are never counted.
2. EX-to-EX hazard: add x5 (ALU_OUT_EX=0x10, RD_EX=5) followed by RS1_EX=5, RS2_EX=5. Required: forwardA=forwardB=10 and ALU_OUT_MEM=0x10. One cycle later, with RS1_EX=5: forwardA=01 and ALU_DATA_WB=0x10.
3. Priority and x0:
   - MEM and WB both write x7, RS1_EX=7 -> forwardA=10.
   - RD_MEM=RD_WB=0 with RegWrite set, RS1_EX=0 -> forwardA=00.
   - RegWrite_MEM=0, RD_MEM=7 -> forwardA=01 (WB match) or 00 (no WB match).
4. Taken branch: Branch_EX=1, ZERO_EX=1, PC_Branch_EX=0x40. Next cycle: PCSrc_MEM=1 and PC_Branch_MEM=0x40. Cycle after: RegWrite_MEM=0 and PCSrc_MEM=0 even though a valid RegWrite instruction was in EX. INSTRET grows by 1 only, for the branch.
5. Load writeback: MemRead_EX=1, MemtoReg_EX=1, RD_EX=9, DATA_MEM_RD=0xDEADBEEF during MEM. Next cycle: ALU_DATA_WB=0xDEADBEEF and RD_WB=9.
6. Counter wrap: CNT_W=4, stream 17 valid instructions -> INSTRET=1 after the 17th retires.

Source files
------------

// File: rtl/ex_mem_wb_pipe.sv
// rtl/ex_mem_wb_pipe.sv - EX/MEM and MEM/WB pipeline registers, branch resolve, forwarding, retire counter
module ex_mem_wb_pipe #(
  parameter int CNT_W = 32,
  parameter int RA_W  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             VALID_EX,
  input  logic             RegWrite_EX,
  input  logic             MemtoReg_EX,
  input  logic             MemRead_EX,
  input  logic             MemWrite_EX,
  input  logic             Branch_EX,
  input  logic             ZERO_EX,
  input  logic [31:0]      ALU_OUT_EX,
  input  logic [31:0]      REG_DATA2_EX_FINAL,
  input  logic [31:0]      PC_Branch_EX,
  input  logic [RA_W-1:0]  RD_EX,
  input  logic [RA_W-1:0]  RS1_EX,
  input  logic [RA_W-1:0]  RS2_EX,
  input  logic             FLUSH_MEM,
  input  logic [31:0]      DATA_MEM_RD,
  output logic [31:0]      ALU_OUT_MEM,
  output logic [31:0]      STORE_DATA_MEM,
  output logic             MemRead_MEM,
  output logic             MemWrite_MEM,
  output logic [31:0]      PC_Branch_MEM,
  output logic             PCSrc_MEM,
  output logic [RA_W-1:0]  RD_WB,
  output logic             RegWrite_WB,
  output logic [31:0]      ALU_DATA_WB,
  output logic [1:0]       forwardA,
  output logic [1:0]       forwardB,
  output logic [CNT_W-1:0] INSTRET
);

  logic            valid_mem_q, valid_mem_d;
  logic            regwrite_mem_q, regwrite_mem_d;
  logic            memtoreg_mem_q, memtoreg_mem_d;
  logic            memread_mem_q, memread_mem_d;
  logic            memwrite_mem_q, memwrite_mem_d;
  logic            branch_mem_q, branch_mem_d;
  logic            zero_mem_q, zero_mem_d;
  logic [31:0]     alu_out_mem_q, alu_out_mem_d;
  logic [31:0]     store_data_mem_q, store_data_mem_d;
  logic [31:0]     pc_branch_mem_q, pc_branch_mem_d;
  logic [RA_W-1:0] rd_mem_q, rd_mem_d;

  logic            valid_wb_q, valid_wb_d;
  logic            regwrite_wb_q, regwrite_wb_d;
  logic            memtoreg_wb_q, memtoreg_wb_d;
  logic [RA_W-1:0] rd_wb_q, rd_wb_d;
  logic [31:0]     alu_out_wb_q, alu_out_wb_d;
  logic [31:0]     mem_data_wb_q, mem_data_wb_d;

  logic [CNT_W-1:0] instret_q, instret_d;

  logic pcsrc;
  logic bubble;
  logic ctl_en;

  assign pcsrc = valid_mem_q & branch_mem_q & zero_mem_q;

  always_comb begin
    bubble = pcsrc | FLUSH_MEM;
    // Wrong-path or externally flushed slots carry nothing; bubbles from EX keep data but lose control.
    ctl_en = VALID_EX & ~bubble;

    valid_mem_d      = ctl_en;
    regwrite_mem_d   = ctl_en & RegWrite_EX;
    memtoreg_mem_d   = ctl_en & MemtoReg_EX;
    memread_mem_d    = ctl_en & MemRead_EX;
    memwrite_mem_d   = ctl_en & MemWrite_EX;
    branch_mem_d     = ctl_en & Branch_EX;
    zero_mem_d       = bubble ? 1'b0 : ZERO_EX;
    alu_out_mem_d    = bubble ? 32'd0 : ALU_OUT_EX;
    store_data_mem_d = bubble ? 32'd0 : REG_DATA2_EX_FINAL;
    pc_branch_mem_d  = bubble ? 32'd0 : PC_Branch_EX;
    rd_mem_d         = bubble ? '0 : RD_EX;

    valid_wb_d    = valid_mem_q;
    regwrite_wb_d = regwrite_mem_q;
    memtoreg_wb_d = memtoreg_mem_q;
    rd_wb_d       = rd_mem_q;
    alu_out_wb_d  = alu_out_mem_q;
    mem_data_wb_d = DATA_MEM_RD;

    instret_d = instret_q + {{(CNT_W-1){1'b0}}, valid_wb_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_mem_q      <= 1'b0;
      regwrite_mem_q   <= 1'b0;
      memtoreg_mem_q   <= 1'b0;
      memread_mem_q    <= 1'b0;
      memwrite_mem_q   <= 1'b0;
      branch_mem_q     <= 1'b0;
      zero_mem_q       <= 1'b0;
      alu_out_mem_q    <= 32'd0;
      store_data_mem_q <= 32'd0;
      pc_branch_mem_q  <= 32'd0;
      rd_mem_q         <= '0;
      valid_wb_q       <= 1'b0;
      regwrite_wb_q    <= 1'b0;
      memtoreg_wb_q    <= 1'b0;
      rd_wb_q          <= '0;
      alu_out_wb_q     <= 32'd0;
      mem_data_wb_q    <= 32'd0;
      instret_q        <= '0;
    end else begin
      valid_mem_q      <= valid_mem_d;
      regwrite_mem_q   <= regwrite_mem_d;
      memtoreg_mem_q   <= memtoreg_mem_d;
      memread_mem_q    <= memread_mem_d;
      memwrite_mem_q   <= memwrite_mem_d;
      branch_mem_q     <= branch_mem_d;
      zero_mem_q       <= zero_mem_d;
      alu_out_mem_q    <= alu_out_mem_d;
      store_data_mem_q <= store_data_mem_d;
      pc_branch_mem_q  <= pc_branch_mem_d;
      rd_mem_q         <= rd_mem_d;
      valid_wb_q       <= valid_wb_d;
      regwrite_wb_q    <= regwrite_wb_d;
      memtoreg_wb_q    <= memtoreg_wb_d;
      rd_wb_q          <= rd_wb_d;
      alu_out_wb_q     <= alu_out_wb_d;
      mem_data_wb_q    <= mem_data_wb_d;
      instret_q        <= instret_d;
    end
  end

  // MEM result is younger than WB, so it wins; x0 is hardwired and never forwarded.
  always_comb begin
    forwardA = 2'b00;
    forwardB = 2'b00;
    if (regwrite_mem_q && (rd_mem_q != '0) && (rd_mem_q == RS1_EX))
      forwardA = 2'b10;
    else if (regwrite_wb_q && (rd_wb_q != '0) && (rd_wb_q == RS1_EX))
      forwardA = 2'b01;
    if (regwrite_mem_q && (rd_mem_q != '0) && (rd_mem_q == RS2_EX))
      forwardB = 2'b10;
    else if (regwrite_wb_q && (rd_wb_q != '0) && (rd_wb_q == RS2_EX))
      forwardB = 2'b01;
  end

  assign ALU_OUT_MEM    = alu_out_mem_q;
  assign STORE_DATA_MEM = store_data_mem_q;
  assign MemRead_MEM    = memread_mem_q;
  assign MemWrite_MEM   = memwrite_mem_q;
  assign PC_Branch_MEM  = pc_branch_mem_q;
  assign PCSrc_MEM      = pcsrc;
  assign RD_WB          = rd_wb_q;
  assign RegWrite_WB    = regwrite_wb_q;
  assign ALU_DATA_WB    = memtoreg_wb_q ? mem_data_wb_q : alu_out_wb_q;
  assign INSTRET        = instret_q;

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// tb/tb_ex_mem_wb_pipe.sv - directed vector bench for ex_mem_wb_pipe
module tb_ex_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        VALID_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX, ZERO_EX;
  logic [31:0] ALU_OUT_EX, REG_DATA2_EX_FINAL, PC_Branch_EX;
  logic [4:0]  RD_EX, RS1_EX, RS2_EX;
  logic        FLUSH_MEM;
  logic [31:0] DATA_MEM_RD;

  logic [31:0] ALU_OUT_MEM, STORE_DATA_MEM, PC_Branch_MEM, ALU_DATA_WB;
  logic        MemRead_MEM, MemWrite_MEM, PCSrc_MEM, RegWrite_WB;
  logic [4:0]  RD_WB;
  logic [1:0]  forwardA, forwardB;
  logic [31:0] INSTRET;

  logic [31:0] alu_mem4, sd_mem4, pcb_mem4, wbdata4;
  logic        mr4, mw4, pcsrc4, rw_wb4;
  logic [4:0]  rd_wb4;
  logic [1:0]  fa4, fb4;
  logic [3:0]  instret4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_mem_wb_pipe dut (
    .clk(clk), .reset(reset), .VALID_EX(VALID_EX), .RegWrite_EX(RegWrite_EX),
    .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .Branch_EX(Branch_EX), .ZERO_EX(ZERO_EX), .ALU_OUT_EX(ALU_OUT_EX),
    .REG_DATA2_EX_FINAL(REG_DATA2_EX_FINAL), .PC_Branch_EX(PC_Branch_EX),
    .RD_EX(RD_EX), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX), .FLUSH_MEM(FLUSH_MEM),
    .DATA_MEM_RD(DATA_MEM_RD), .ALU_OUT_MEM(ALU_OUT_MEM), .STORE_DATA_MEM(STORE_DATA_MEM),
    .MemRead_MEM(MemRead_MEM), .MemWrite_MEM(MemWrite_MEM), .PC_Branch_MEM(PC_Branch_MEM),
    .PCSrc_MEM(PCSrc_MEM), .RD_WB(RD_WB), .RegWrite_WB(RegWrite_WB),
    .ALU_DATA_WB(ALU_DATA_WB), .forwardA(forwardA), .forwardB(forwardB), .INSTRET(INSTRET)
  );

  ex_mem_wb_pipe #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .VALID_EX(VALID_EX), .RegWrite_EX(RegWrite_EX),
    .MemtoReg_EX(MemtoReg_EX), .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
    .Branch_EX(Branch_EX), .ZERO_EX(ZERO_EX), .ALU_OUT_EX(ALU_OUT_EX),
    .REG_DATA2_EX_FINAL(REG_DATA2_EX_FINAL), .PC_Branch_EX(PC_Branch_EX),
    .RD_EX(RD_EX), .RS1_EX(RS1_EX), .RS2_EX(RS2_EX), .FLUSH_MEM(FLUSH_MEM),
    .DATA_MEM_RD(DATA_MEM_RD), .ALU_OUT_MEM(alu_mem4), .STORE_DATA_MEM(sd_mem4),
    .MemRead_MEM(mr4), .MemWrite_MEM(mw4), .PC_Branch_MEM(pcb_mem4),
    .PCSrc_MEM(pcsrc4), .RD_WB(rd_wb4), .RegWrite_WB(rw_wb4),
    .ALU_DATA_WB(wbdata4), .forwardA(fa4), .forwardB(fb4), .INSTRET(instret4)
  );

  // ctl = {reset, VALID, RegWrite, MemtoReg, MemRead, MemWrite, Branch, ZERO}
  typedef struct {
    logic [7:0]  ctl;
    logic [31:0] alu, sd, pcb;
    logic [4:0]  rd, rs1, rs2;
    logic        fl;
    logic [31:0] dm;
  } in_t;

  // flg = {MemRead_MEM, MemWrite_MEM, PCSrc_MEM, RegWrite_WB}
  typedef struct {
    logic [31:0] alu_mem, sd_mem, pcb_mem;
    logic [3:0]  flg;
    logic [4:0]  rd_wb;
    logic [31:0] wbdata;
    logic [1:0]  fa, fb;
    logic [31:0] instret;
  } exp_t;

  typedef struct {
    in_t  i;
    exp_t e;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input in_t v);
    {reset, VALID_EX, RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, Branch_EX, ZERO_EX} = v.ctl;
    ALU_OUT_EX         = v.alu;
    REG_DATA2_EX_FINAL = v.sd;
    PC_Branch_EX       = v.pcb;
    RD_EX              = v.rd;
    RS1_EX             = v.rs1;
    RS2_EX             = v.rs2;
    FLUSH_MEM          = v.fl;
    DATA_MEM_RD        = v.dm;
  endtask

  function automatic in_t simple(input logic [7:0] ctl, input logic [31:0] alu,
                                 input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    in_t v;
    v = '{ctl, alu, 32'h0, 32'h0, rd, rs1, rs2, 1'b0, 32'h0};
    return v;
  endfunction

  initial begin
    drive(simple(8'b1000_0000, 32'h0, 5'd0, 5'd0, 5'd0));

    vecs[0]  = '{'{8'b0110_0000, 32'h10,  32'h0,    32'h0,  5'd5,  5'd1,  5'd2,  1'b0, 32'h0},
                 '{32'h0,   32'h0,    32'h0,  4'b0000, 5'd0,  32'h0,        2'b00, 2'b00, 32'd0}};
    vecs[1]  = '{'{8'b0110_0000, 32'h20,  32'h0,    32'h0,  5'd6,  5'd5,  5'd5,  1'b0, 32'h0},
                 '{32'h10,  32'h0,    32'h0,  4'b0000, 5'd0,  32'h0,        2'b10, 2'b10, 32'd0}};
    vecs[2]  = '{'{8'b0110_0000, 32'h30,  32'h0,    32'h0,  5'd7,  5'd5,  5'd6,  1'b0, 32'h0},
                 '{32'h20,  32'h0,    32'h0,  4'b0001, 5'd5,  32'h10,       2'b01, 2'b10, 32'd0}};
    vecs[3]  = '{'{8'b0110_0000, 32'h40,  32'h0,    32'h0,  5'd7,  5'd7,  5'd0,  1'b0, 32'h0},
                 '{32'h30,  32'h0,    32'h0,  4'b0001, 5'd6,  32'h20,       2'b10, 2'b00, 32'd1}};
    vecs[4]  = '{'{8'b0110_0000, 32'h50,  32'h0,    32'h0,  5'd0,  5'd7,  5'd7,  1'b0, 32'h0},
                 '{32'h40,  32'h0,    32'h0,  4'b0001, 5'd7,  32'h30,       2'b10, 2'b10, 32'd2}};
    vecs[5]  = '{'{8'b0110_0000, 32'h60,  32'h0,    32'h0,  5'd0,  5'd0,  5'd7,  1'b0, 32'h0},
                 '{32'h50,  32'h0,    32'h0,  4'b0001, 5'd7,  32'h40,       2'b00, 2'b01, 32'd3}};
    vecs[6]  = '{'{8'b0100_0100, 32'h70,  32'h1234, 32'h0,  5'd7,  5'd0,  5'd0,  1'b0, 32'h0},
                 '{32'h60,  32'h0,    32'h0,  4'b0001, 5'd0,  32'h50,       2'b00, 2'b00, 32'd4}};
    vecs[7]  = '{'{8'b0011_1111, 32'h80,  32'h5555, 32'h99, 5'd7,  5'd7,  5'd3,  1'b0, 32'h0},
                 '{32'h70,  32'h1234, 32'h0,  4'b0101, 5'd0,  32'h60,       2'b00, 2'b00, 32'd5}};
    vecs[8]  = '{'{8'b0111_1000, 32'h100, 32'h0,    32'h0,  5'd9,  5'd7,  5'd7,  1'b0, 32'hAAAA0000},
                 '{32'h80,  32'h5555, 32'h99, 4'b0000, 5'd7,  32'h70,       2'b00, 2'b00, 32'd6}};
    vecs[9]  = '{'{8'b0110_0000, 32'h110, 32'h0,    32'h0,  5'd10, 5'd1,  5'd7,  1'b0, 32'hDEADBEEF},
                 '{32'h100, 32'h0,    32'h0,  4'b1000, 5'd7,  32'h80,       2'b00, 2'b00, 32'd7}};
    vecs[10] = '{'{8'b0110_0000, 32'h120, 32'h0,    32'h0,  5'd11, 5'd9,  5'd10, 1'b0, 32'h11111111},
                 '{32'h110, 32'h0,    32'h0,  4'b0001, 5'd9,  32'hDEADBEEF, 2'b01, 2'b10, 32'd7}};
    vecs[11] = '{'{8'b0100_0011, 32'h130, 32'h0,    32'h40, 5'd0,  5'd0,  5'd0,  1'b0, 32'h0},
                 '{32'h120, 32'h0,    32'h0,  4'b0001, 5'd10, 32'h110,      2'b00, 2'b00, 32'd8}};
    vecs[12] = '{'{8'b0110_0000, 32'h140, 32'h0,    32'h0,  5'd12, 5'd11, 5'd0,  1'b0, 32'h0},
                 '{32'h130, 32'h0,    32'h40, 4'b0011, 5'd11, 32'h120,      2'b01, 2'b00, 32'd9}};
    vecs[13] = '{'{8'b0110_0000, 32'h150, 32'h0,    32'h0,  5'd13, 5'd12, 5'd0,  1'b0, 32'h0},
                 '{32'h0,   32'h0,    32'h0,  4'b0000, 5'd0,  32'h130,      2'b00, 2'b00, 32'd10}};
    vecs[14] = '{'{8'b0000_0000, 32'h0,   32'h0,    32'h0,  5'd0,  5'd13, 5'd12, 1'b0, 32'h0},
                 '{32'h150, 32'h0,    32'h0,  4'b0000, 5'd0,  32'h0,        2'b10, 2'b00, 32'd11}};
    vecs[15] = '{'{8'b0110_0000, 32'h160, 32'h0,    32'h0,  5'd14, 5'd0,  5'd0,  1'b1, 32'h0},
                 '{32'h0,   32'h0,    32'h0,  4'b0001, 5'd13, 32'h150,      2'b00, 2'b00, 32'd11}};
    vecs[16] = '{'{8'b1110_0000, 32'h170, 32'h0,    32'h0,  5'd15, 5'd13, 5'd14, 1'b0, 32'h0},
                 '{32'h0,   32'h0,    32'h0,  4'b0000, 5'd0,  32'h0,        2'b00, 2'b00, 32'd12}};
    vecs[17] = '{'{8'b0000_0000, 32'h0,   32'h0,    32'h0,  5'd0,  5'd0,  5'd0,  1'b0, 32'h0},
                 '{32'h0,   32'h0,    32'h0,  4'b0000, 5'd0,  32'h0,        2'b00, 2'b00, 32'd0}};

    repeat (2) @(posedge clk);
    @(negedge clk);
    drive(simple(8'b0000_0000, 32'h0, 5'd0, 5'd0, 5'd0));
    #1;
    chk("rst_alu_mem",  ALU_OUT_MEM, 32'h0);
    chk("rst_pcsrc",    {31'h0, PCSrc_MEM}, 32'h0);
    chk("rst_wbdata",   ALU_DATA_WB, 32'h0);
    chk("rst_rw_wb",    {31'h0, RegWrite_WB}, 32'h0);
    chk("rst_fwd",      {28'h0, forwardA, forwardB}, 32'h0);
    chk("rst_instret",  INSTRET, 32'h0);
    chk("rst_instret4", {28'h0, instret4}, 32'h0);

    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      drive(vecs[k].i);
      #1;
      chk($sformatf("v%0d_alu_mem", k), ALU_OUT_MEM, vecs[k].e.alu_mem);
      chk($sformatf("v%0d_sd_mem", k),  STORE_DATA_MEM, vecs[k].e.sd_mem);
      chk($sformatf("v%0d_pcb_mem", k), PC_Branch_MEM, vecs[k].e.pcb_mem);
      chk($sformatf("v%0d_flags", k),   {28'h0, MemRead_MEM, MemWrite_MEM, PCSrc_MEM, RegWrite_WB},
          {28'h0, vecs[k].e.flg});
      chk($sformatf("v%0d_rd_wb", k),   {27'h0, RD_WB}, {27'h0, vecs[k].e.rd_wb});
      chk($sformatf("v%0d_wbdata", k),  ALU_DATA_WB, vecs[k].e.wbdata);
      chk($sformatf("v%0d_fwdA", k),    {30'h0, forwardA}, {30'h0, vecs[k].e.fa});
      chk($sformatf("v%0d_fwdB", k),    {30'h0, forwardB}, {30'h0, vecs[k].e.fb});
      chk($sformatf("v%0d_instret", k), INSTRET, vecs[k].e.instret);
      chk($sformatf("v%0d_instret4", k), {28'h0, instret4}, {28'h0, vecs[k].e.instret[3:0]});
    end

    // Reset lands while valid writers sit in both MEM and WB.
    @(negedge clk);
    drive(simple(8'b0110_0000, 32'hA, 5'd1, 5'd0, 5'd0));
    @(negedge clk);
    drive(simple(8'b0110_0000, 32'hB, 5'd2, 5'd0, 5'd0));
    @(negedge clk);
    drive(simple(8'b1110_0000, 32'hC, 5'd3, 5'd2, 5'd1));
    #1;
    chk("mid_pre_fwdA", {30'h0, forwardA}, 32'h2);
    chk("mid_pre_fwdB", {30'h0, forwardB}, 32'h1);
    @(negedge clk);
    drive(simple(8'b0000_0000, 32'h0, 5'd0, 5'd2, 5'd1));
    #1;
    chk("mid_alu_mem", ALU_OUT_MEM, 32'h0);
    chk("mid_rd_wb",   {27'h0, RD_WB}, 32'h0);
    chk("mid_rw_wb",   {31'h0, RegWrite_WB}, 32'h0);
    chk("mid_wbdata",  ALU_DATA_WB, 32'h0);
    chk("mid_fwd",     {28'h0, forwardA, forwardB}, 32'h0);
    chk("mid_instret", INSTRET, 32'h0);
    repeat (3) @(negedge clk);
    #1;
    chk("mid_late_instret",  INSTRET, 32'h0);
    chk("mid_late_instret4", {28'h0, instret4}, 32'h0);

    // 17 retirements: the 4-bit counter passes 15 -> 0 and lands on 1.
    @(negedge clk);
    drive(simple(8'b1000_0000, 32'h0, 5'd0, 5'd0, 5'd0));
    for (int k = 0; k < 21; k++) begin
      @(negedge clk);
      if (k < 17) drive(simple(8'b0100_0000, k, 5'd0, 5'd0, 5'd0));
      else        drive(simple(8'b0000_0000, 32'h0, 5'd0, 5'd0, 5'd0));
      #1;
      if (k == 18) begin
        chk("wrap_16_instret",  INSTRET, 32'd16);
        chk("wrap_16_instret4", {28'h0, instret4}, 32'd0);
      end
      if (k == 19 || k == 20) begin
        chk($sformatf("wrap_17_instret_%0d", k),  INSTRET, 32'd17);
        chk($sformatf("wrap_17_instret4_%0d", k), {28'h0, instret4}, 32'd1);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
